// File: rtl/psum_combine_acc_pkg.sv
// Shared types and helpers for the partial-sum combine/accumulate block and
// for any array-side reference model that needs the same combine arithmetic.
package psum_combine_acc_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int PSUM_BW  = 24;
    localparam int PSUM_BW2 = 12;
    localparam int BW2      = 2;

    // Beat counter width; a single-beat group still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Default-width combine: full word, or (sext(hi) <<< BW2) + sext(lo).
    function automatic logic signed [PSUM_BW-1:0] psum_combine(
        input logic              mode,
        input logic [PSUM_BW-1:0] data
    );
        logic signed [PSUM_BW-1:0] hi_x;
        logic signed [PSUM_BW-1:0] lo_x;
        hi_x = {{(PSUM_BW-PSUM_BW2){data[PSUM_BW-1]}}, data[PSUM_BW-1:PSUM_BW2]};
        lo_x = {{(PSUM_BW-PSUM_BW2){data[PSUM_BW2-1]}}, data[PSUM_BW2-1:0]};
        return mode ? (hi_x <<< BW2) + lo_x : signed'(data);
    endfunction

endpackage

// File: rtl/psum_combine_acc_if.sv
// Input beat / output result handshake bundle between the MAC column bottom,
// the combine/accumulate block and the output write port.
interface psum_combine_acc_if #(
    parameter int psum_bw = 24
) ();
    logic               act_mode;
    logic               relu_en;
    logic               in_valid;
    logic               in_ready;
    logic [psum_bw-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [psum_bw-1:0] out_data;
    logic               busy;

    modport slave (
        input  act_mode, relu_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output act_mode, relu_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/psum_combine_acc_unpack.sv
// Combinational recombination of a packed split-activation psum word into a
// full-width signed psum; full-mode words pass straight through.
module psum_unpack #(
    parameter int psum_bw  = 24,
    parameter int psum_bw2 = 12,
    parameter int bw2      = 2
) (
    input  logic                      i_mode,
    input  logic        [psum_bw-1:0] i_data,
    output logic signed [psum_bw-1:0] o_comb
);
    localparam int HI_W = psum_bw - psum_bw2;

    logic signed [psum_bw-1:0] w_hi_x;
    logic signed [psum_bw-1:0] w_lo_x;

    assign w_hi_x = {{(psum_bw-HI_W){i_data[psum_bw-1]}}, i_data[psum_bw-1:psum_bw2]};
    assign w_lo_x = {{(psum_bw-psum_bw2){i_data[psum_bw2-1]}}, i_data[psum_bw2-1:0]};

    // Sums wrap modulo 2**psum_bw by construction of the result width.
    assign o_comb = i_mode ? (w_hi_x <<< bw2) + w_lo_x : signed'(i_data);
endmodule

// File: rtl/psum_combine_acc.sv
// Accumulates acc_len combined psums per result, applies optional ReLU and
// holds the result on a valid/ready output with pass-through backpressure.
module psum_combine_acc
    import psum_combine_acc_pkg::*;
#(
    parameter int psum_bw  = 24,
    parameter int psum_bw2 = 12,
    parameter int bw2      = 2,
    parameter int acc_len  = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    psum_combine_acc_if.slave   bus
);
    localparam int CNT_W = cnt_width(acc_len);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(acc_len - 1);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic        [CNT_W-1:0]   r_cnt;
    logic                      r_mode_q;
    logic signed [psum_bw-1:0] r_acc;
    logic        [psum_bw-1:0] r_out_data;

    logic                      w_first;
    logic                      w_last;
    logic                      w_mode;
    logic                      w_in_ready;
    logic                      w_beat;
    logic signed [psum_bw-1:0] w_comb;
    logic signed [psum_bw-1:0] w_acc_next;

    function automatic logic signed [psum_bw-1:0] relu(
        input logic signed [psum_bw-1:0] s,
        input logic                      en
    );
        return (s[psum_bw-1] && en) ? '0 : s;
    endfunction

    // In HOLD the counter is already 0, so a beat there opens the next group.
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_mode     = w_first ? bus.act_mode : r_mode_q;
    assign w_in_ready = (r_state == ST_ACC) ? 1'b1 : bus.out_ready;
    assign w_beat     = bus.in_valid && w_in_ready;

    psum_unpack #(
        .psum_bw  (psum_bw),
        .psum_bw2 (psum_bw2),
        .bw2      (bw2)
    ) u_unpack (
        .i_mode (w_mode),
        .i_data (bus.in_data),
        .o_comb (w_comb)
    );

    assign w_acc_next = w_first ? w_comb : r_acc + w_comb;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_beat && w_last) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) w_state_nxt = (w_beat && w_last) ? ST_HOLD : ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_ACC;
        else          r_state <= w_state_nxt;
    end

    // Beat acceptance: accumulate, count, and capture the result on the last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_mode_q   <= 1'b0;
            r_acc      <= '0;
            r_out_data <= '0;
        end else if (w_beat) begin
            r_acc    <= w_acc_next;
            r_mode_q <= w_mode;
            if (w_last) begin
                r_cnt      <= '0;
                r_out_data <= relu(w_acc_next, bus.relu_en);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_cnt != '0) || (r_state == ST_HOLD);
endmodule

// File: tb/tb_psum_combine_acc.sv
// Directed bench: standalone unpack table, single-beat table, and hand-written
// multi-cycle sequences on three instances with different group lengths.
module tb_psum_combine_acc;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    psum_combine_acc_if #(.psum_bw(24)) if1 ();
    psum_combine_acc_if #(.psum_bw(24)) if2 ();
    psum_combine_acc_if #(.psum_bw(24)) if3 ();

    psum_combine_acc #(.psum_bw(24), .psum_bw2(12), .bw2(2), .acc_len(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));
    psum_combine_acc #(.psum_bw(24), .psum_bw2(12), .bw2(2), .acc_len(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave));
    psum_combine_acc #(.psum_bw(24), .psum_bw2(12), .bw2(2), .acc_len(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(if3.slave));

    logic               u_mode;
    logic        [23:0] u_data;
    logic signed [23:0] u_comb;
    psum_unpack #(.psum_bw(24), .psum_bw2(12), .bw2(2)) u_unp (
        .i_mode(u_mode), .i_data(u_data), .o_comb(u_comb));

    typedef struct {
        logic        mode;
        logic        relu;
        logic [23:0] data;
        logic [23:0] comb;
        logic [23:0] out;
    } vec_t;

    vec_t vecs [8];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 24'h001003, 24'h000007, 24'h000007};
        vecs[1] = '{1'b1, 1'b0, 24'hFFF002, 24'hFFFFFE, 24'hFFFFFE};
        vecs[2] = '{1'b1, 1'b1, 24'hFFF002, 24'hFFFFFE, 24'h000000};
        vecs[3] = '{1'b0, 1'b0, 24'h123456, 24'h123456, 24'h123456};
        vecs[4] = '{1'b0, 1'b1, 24'h800000, 24'h800000, 24'h000000};
        vecs[5] = '{1'b0, 1'b0, 24'h800000, 24'h800000, 24'h800000};
        vecs[6] = '{1'b1, 1'b0, 24'h7FF7FF, 24'h0027FB, 24'h0027FB};
        vecs[7] = '{1'b1, 1'b1, 24'h800800, 24'hFFD800, 24'h000000};

        {if1.act_mode, if1.relu_en, if1.in_valid, if1.in_data, if1.out_ready} = {3'b000, 24'h0, 1'b1};
        {if2.act_mode, if2.relu_en, if2.in_valid, if2.in_data, if2.out_ready} = {3'b000, 24'h0, 1'b1};
        {if3.act_mode, if3.relu_en, if3.in_valid, if3.in_data, if3.out_ready} = {3'b000, 24'h0, 1'b1};
        u_mode  = 1'b0;
        u_data  = 24'h0;
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {23'd0, if3.out_valid}, 24'd0);
        check("rst_out_data",  if3.out_data, 24'd0);
        check("rst_busy",      {23'd0, if3.busy}, 24'd0);
        check("rst_in_ready",  {23'd0, if3.in_ready}, 24'd1);
        check("rst_in_ready1", {23'd0, if1.in_ready}, 24'd1);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            u_mode = vecs[i].mode;
            u_data = vecs[i].data;
            #1;
            check($sformatf("unpack[%0d]", i), u_comb, vecs[i].comb);
        end

        // Back-to-back single-beat groups while the output is drained every cycle
        for (int i = 0; i < 8; i++) begin
            if1.act_mode = vecs[i].mode;
            if1.relu_en  = vecs[i].relu;
            if1.in_data  = vecs[i].data;
            if1.in_valid = 1'b1;
            tick();
            check($sformatf("len1_valid[%0d]", i), {23'd0, if1.out_valid}, 24'd1);
            check($sformatf("len1_data[%0d]", i), if1.out_data, vecs[i].out);
        end
        if1.in_valid = 1'b0;
        tick();
        check("len1_drain_valid", {23'd0, if1.out_valid}, 24'd0);
        check("len1_drain_busy",  {23'd0, if1.busy}, 24'd0);

        if3.in_valid = 1'b1;
        if3.in_data  = 24'd5;
        tick();
        if3.in_data  = 24'hFFFFFE;
        tick();
        check("len3_mid_valid", {23'd0, if3.out_valid}, 24'd0);
        check("len3_mid_busy",  {23'd0, if3.busy}, 24'd1);
        if3.in_data  = 24'd10;
        tick();
        check("len3_valid", {23'd0, if3.out_valid}, 24'd1);
        check("len3_data",  if3.out_data, 24'd13);
        if3.in_valid = 1'b0;
        tick();
        check("len3_pulse_end", {23'd0, if3.out_valid}, 24'd0);

        if3.out_ready = 1'b0;
        if3.in_valid  = 1'b1;
        if3.in_data   = 24'd1;
        tick();
        if3.in_data   = 24'd2;
        tick();
        if3.in_data   = 24'd3;
        tick();
        if3.in_data   = 24'd100;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_valid[%0d]", i),    {23'd0, if3.out_valid}, 24'd1);
            check($sformatf("bp_data[%0d]", i),     if3.out_data, 24'd6);
            check($sformatf("bp_in_ready[%0d]", i), {23'd0, if3.in_ready}, 24'd0);
            tick();
        end
        if3.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {23'd0, if3.in_ready}, 24'd1);
        tick();
        check("bp_overlap_valid", {23'd0, if3.out_valid}, 24'd0);
        check("bp_overlap_busy",  {23'd0, if3.busy}, 24'd1);
        if3.in_data = 24'd200;
        tick();
        check("bp_cnt2_valid", {23'd0, if3.out_valid}, 24'd0);
        if3.in_data = 24'd300;
        tick();
        check("bp_next_valid", {23'd0, if3.out_valid}, 24'd1);
        check("bp_next_data",  if3.out_data, 24'd600);
        if3.in_valid = 1'b0;
        tick();

        if2.act_mode = 1'b1;
        if2.in_data  = 24'h001001;
        if2.in_valid = 1'b1;
        tick();
        if2.act_mode = 1'b0;
        tick();
        check("mode_latch_valid", {23'd0, if2.out_valid}, 24'd1);
        check("mode_latch_data",  if2.out_data, 24'd10);
        if2.in_valid = 1'b0;
        tick();

        for (int r = 0; r < 2; r++) begin
            if2.relu_en  = r[0];
            if2.in_valid = 1'b1;
            if2.in_data  = 24'h7FFFFF;
            tick();
            if2.in_data  = 24'h000001;
            tick();
            check($sformatf("wrap_valid[relu=%0d]", r), {23'd0, if2.out_valid}, 24'd1);
            check($sformatf("wrap_data[relu=%0d]", r),  if2.out_data, (r == 0) ? 24'h800000 : 24'h000000);
            if2.in_valid = 1'b0;
            tick();
        end

        if3.in_valid = 1'b1;
        if3.in_data  = 24'd7;
        tick();
        if3.in_data  = 24'd8;
        tick();
        if3.in_valid = 1'b0;
        check("rstmid_busy_before", {23'd0, if3.busy}, 24'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_busy",  {23'd0, if3.busy}, 24'd0);
        check("rstmid_valid", {23'd0, if3.out_valid}, 24'd0);
        check("rstmid_data",  if3.out_data, 24'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        if3.in_valid = 1'b1;
        if3.in_data  = 24'd1;
        tick();
        if3.in_data  = 24'd2;
        tick();
        if3.in_data  = 24'd4;
        tick();
        check("rstmid_next_valid", {23'd0, if3.out_valid}, 24'd1);
        check("rstmid_next_data",  if3.out_data, 24'd7);
        if3.in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
